mdu_sequencer: RTL
==================

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have port `clk`: input, 1 bit, single clock; all state changes on its rising edge.
REQ-002 SHALL have port `rst_n`: input, 1 bit, reset, asynchronous, active-low.
REQ-003 SHALL have port `start`: input, 1 bit, RV32M instruction present in EX (opcode 0110011, func7 0000001).
REQ-004 SHALL have port `func3`: input, 3 bits, M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port `op1`: input, 32 bits, forwarded operand A (multiplicand/dividend).
REQ-006 SHALL have port `op2`: input, 32 bits, forwarded operand B (multiplier/divisor).
REQ-007 SHALL have port `alu_rd`: input, 5 bits, destination register.
REQ-008 SHALL have port `pipeline_flush`: input, 1 bit, abort in-flight op.
REQ-009 SHALL have port `stall`: output, 1 bit, freeze IF/ID/EX while op pending.
REQ-010 SHALL have port `done`: output, 1 bit, one-cycle pulse, result valid.
REQ-011 SHALL have port `result`: output, 32 bits, M-op result; valid only while done=1.
REQ-012 SHALL have port `wb_rd`: output, 5 bits, latched alu_rd; valid while done=1, else 0.
REQ-013 SHALL have port `wb_reg_file`: output, 1 bit, equals done.
REQ-014 SHALL have port `busy`: output, 1 bit, state != IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-016 IDLE: start=1 and pipeline_flush=0 -> accept; latch func3, alu_rd, |op1|, |op2| (magnitudes per signedness of op), result-sign flags; go RUN, iteration counter=0.
REQ-017 Accept cycle = cycle 0; RUN occupies cycles 1..32 (one iteration per cycle, counter 0..31, 5-bit, no wrap beyond 31); FIX cycle 33; DONE cycle 34; IDLE cycle 35.
REQ-018 Multiply: unsigned shift-add over 32 iterations into 64-bit product; FIX negates 64-bit product if sign flag set; MUL returns bits[31:0], MULH/MULHSU/MULHU bits[63:32].
REQ-019 Signedness: MULH both signed; MULHSU op1 signed, op2 unsigned; MULHU/MUL magnitudes unsigned (MUL low word sign-independent).
REQ-020 Divide: restoring division on magnitudes, 32 iterations, 33-bit partial remainder; FIX negates quotient if operand signs differ (DIV), remainder takes dividend sign (REM).
REQ-021 Special cases detected at accept, skip RUN/FIX, go DONE next cycle (done in cycle 1): divisor 0 -> DIV/DIVU 0xFFFFFFFF, REM/REMU = op1; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-022 stall SHALL = (IDLE and start and not pipeline_flush) or RUN or FIX; low in DONE so pipeline advances with result.
REQ-023 DONE: done=1, wb_reg_file=1, wb_rd=latched rd for exactly one cycle, then IDLE unconditionally.
REQ-024 start while RUN/FIX/DONE SHALL be ignored (operands already latched); back-to-back op accepted in the IDLE cycle after DONE.
REQ-025 pipeline_flush=1 in RUN or FIX -> IDLE next edge, no done pulse; stall drops the cycle after the flush.
REQ-026 pipeline_flush=1 in DONE SHALL NOT suppress done (result already committed).
REQ-027 pipeline_flush=1 coincident with start in IDLE -> not accepted, stall=0.
REQ-028 All arithmetic SHALL be modulo 2^32/2^64; no exceptions raised.

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, counter=0, product/remainder/quotient registers=0, latched rd=0.
REQ-030 During and after reset until next accept: stall=0, done=0, busy=0, result=0, wb_rd=0, wb_reg_file=0.
REQ-031 Reset mid-RUN SHALL abort with no done pulse; first start after rst_n rises is accepted normally.

Verification
REQ-032 MUL op1=7, op2=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, done at cycle 34, stall high cycles 0..33.
REQ-033 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-035 DIVU 5/0 -> 0xFFFFFFFF and REM 0x80000000 / 0xFFFFFFFF -> 0, each with done in cycle 1.
REQ-036 Flush at cycle 10 of a DIV -> IDLE at cycle 11, stall=0 at cycle 11, no done; following MUL 3x4 -> 12 at its cycle 34.
REQ-037 rst_n low at cycle 20 of a MUL -> all outputs 0 immediately, no done; next op completes correctly.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply and restoring divide,
// one iteration per cycle, with the EX-stage stall and writeback handshake.
module mdu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  func3,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [4:0]  alu_rd,
    input  logic        pipeline_flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_file,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic [4:0]  cnt;
    logic        neg_q;
    logic        rneg_q;
    logic [31:0] res_q;
    logic [63:0] prod;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] dvsr;

    // Operand sign handling: op1 is signed for MULH/MULHSU/DIV/REM, op2 for MULH/DIV/REM.
    logic        a_sgn, b_sgn, is_div, div0, ovf, special;
    logic [31:0] a_mag, b_mag, spec_res;

    always_comb begin
        is_div   = func3[2];
        a_sgn    = op1[31] & ((func3 == 3'b001) | (func3 == 3'b010) |
                              (func3 == 3'b100) | (func3 == 3'b110));
        b_sgn    = op2[31] & ((func3 == 3'b001) | (func3 == 3'b100) | (func3 == 3'b110));
        a_mag    = a_sgn ? (32'd0 - op1) : op1;
        b_mag    = b_sgn ? (32'd0 - op2) : op2;
        div0     = is_div & (op2 == 32'd0);
        ovf      = is_div & ~func3[0] & (op1 == 32'h8000_0000) & (op2 == 32'hFFFF_FFFF);
        special  = div0 | ovf;
        if (div0)
            spec_res = func3[1] ? op1 : 32'hFFFF_FFFF;
        else
            spec_res = func3[1] ? 32'd0 : 32'h8000_0000;
    end

    // Restoring step: trial-subtract the divisor from the shifted partial remainder.
    logic [33:0] diff;
    assign diff = {rem, quo[31]} - {2'b00, dvsr};

    logic [63:0] prod_s;
    logic [31:0] quo_s, rem_s, fix_res;

    always_comb begin
        prod_s = neg_q  ? (64'd0 - prod) : prod;
        quo_s  = neg_q  ? (32'd0 - quo) : quo;
        rem_s  = rneg_q ? (32'd0 - rem[31:0]) : rem[31:0];
        if (f3_q[2])
            fix_res = f3_q[1] ? rem_s : quo_s;
        else
            fix_res = (f3_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            f3_q   <= '0;
            rd_q   <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            res_q  <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !pipeline_flush) begin
                        f3_q   <= func3;
                        rd_q   <= alu_rd;
                        cnt    <= '0;
                        neg_q  <= a_sgn ^ b_sgn;
                        rneg_q <= a_sgn;
                        prod   <= '0;
                        mcand  <= {32'd0, a_mag};
                        mplier <= b_mag;
                        rem    <= '0;
                        quo    <= a_mag;
                        dvsr   <= b_mag;
                        if (special) begin
                            res_q <= spec_res;
                            state <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (pipeline_flush) begin
                        state <= IDLE;
                    end else begin
                        // Both datapaths step every cycle; FIX picks the one that matters.
                        if (mplier[0])
                            prod <= prod + mcand;
                        mcand  <= {mcand[62:0], 1'b0};
                        mplier <= {1'b0, mplier[31:1]};
                        if (!diff[33]) begin
                            rem <= diff[32:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= {rem[31:0], quo[31]};
                            quo <= {quo[30:0], 1'b0};
                        end
                        if (cnt == 5'd31)
                            state <= FIX;
                        else
                            cnt <= cnt + 5'd1;
                    end
                end
                FIX: begin
                    if (pipeline_flush) begin
                        state <= IDLE;
                    end else begin
                        res_q <= fix_res;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign stall       = ((state == IDLE) & start & ~pipeline_flush) | (state == RUN) | (state == FIX);
    assign done        = (state == DONE);
    assign wb_reg_file = done;
    assign busy        = (state != IDLE);
    assign result      = done ? res_q : 32'd0;
    assign wb_rd       = done ? rd_q : 5'd0;

endmodule
